// File: rtl/fp_result_packer_if.sv
// Handshake bundle for the floating-point result packer.
// Upstream side: in_valid/in_ready plus the classified result fields.
// Downstream side: out_valid/out_ready plus the packed IEEE-754 word and flags.
// The packer uses the slave modport; whoever drives results in and drains words out uses master.
interface fp_result_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [23:0] in_mant;
    logic [2:0]  in_special;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fp_result_packer.sv
// fp_result_packer: two-stage pipeline turning a classified FP result
// (sign, 10-bit biased exponent, 24-bit significand, class code) into an
// IEEE-754 single-precision word plus {invalid, overflow, underflow} flags.
// S1 classifies and range-checks the exponent, S2 assembles the word.
// Optional feature macro: PACKER_FTZ_EN -- when defined, underflowing results
// flush to signed zero instead of being denormalised by right-shifting.
module fp_result_packer (
    input  logic              clk,
    input  logic              rst_n,
    fp_result_packer_if.slave bus
);

    // Result kinds decided in S1 and consumed by the S2 assembler
    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NORM,
        CLS_OVF,
        CLS_UNF
    } resultClass_e;

    logic         s1Valid_q,  s1Valid_d;
    logic         s1Sign_q,   s1Sign_d;
    resultClass_e s1Class_q,  s1Class_d;
    logic [7:0]   s1Exp_q,    s1Exp_d;
    logic [22:0]  s1Frac_q,   s1Frac_d;

    logic         s2Valid_q,  s2Valid_d;
    logic [31:0]  s2Result_q, s2Result_d;
    logic [2:0]   s2Flags_q,  s2Flags_d;

    logic         s2Advance;
    logic         s1Advance;
    logic         accept;

    logic signed [9:0] inExpS;
    resultClass_e      inClass;
    logic [22:0]       unfFrac;
    logic [22:0]       inFrac;

    // S2 may load whenever it is empty or its word is being drained this cycle;
    // S1 may load whenever it is empty or it hands its entry to S2 this cycle.
    assign s2Advance    = !s2Valid_q || bus.out_ready;
    assign s1Advance    = !s1Valid_q || s2Advance;
    assign bus.in_ready = rst_n && s1Advance;
    assign accept       = bus.in_valid && bus.in_ready;

    assign inExpS = bus.in_exp;

    // Classify the incoming result; mantissa-zero wins over any exponent range check
    always_comb begin
        inClass = CLS_NAN;
        case (bus.in_special)
            3'b000: begin
                if (bus.in_mant == 24'd0) begin
                    inClass = CLS_ZERO;
                end else if (inExpS >= 10'sd255) begin
                    inClass = CLS_OVF;
                end else if (inExpS >= 10'sd1) begin
                    inClass = CLS_NORM;
                end else begin
                    inClass = CLS_UNF;
                end
            end
            3'b001:  inClass = CLS_ZERO;
            3'b010:  inClass = CLS_INF;
            default: inClass = CLS_NAN;
        endcase
    end

`ifdef PACKER_FTZ_EN
    assign unfFrac = 23'd0;
`else
    logic [10:0] unfShift;
    logic [22:0] unfShifted;

    // A biased exponent e <= 0 becomes a denormal by shifting the significand
    // right by 1-e; the sign-extended exponent keeps very negative values huge.
    assign unfShift   = 11'd1 - {bus.in_exp[9], bus.in_exp};
    assign unfShifted = 23'(bus.in_mant >> unfShift);
    assign unfFrac    = (unfShift > 11'd23) ? 23'd0 : unfShifted;
`endif

    assign inFrac = (inClass == CLS_UNF) ? unfFrac : bus.in_mant[22:0];

    // S1 next state: load a new entry on accept, otherwise drain or hold
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Sign_d  = s1Sign_q;
        s1Class_d = s1Class_q;
        s1Exp_d   = s1Exp_q;
        s1Frac_d  = s1Frac_q;
        if (s1Advance) begin
            s1Valid_d = accept;
        end
        if (accept) begin
            s1Sign_d  = bus.in_sign;
            s1Class_d = inClass;
            s1Exp_d   = bus.in_exp[7:0];
            s1Frac_d  = inFrac;
        end
    end

    // S2 next state: assemble the IEEE word and flags from the S1 classification
    always_comb begin
        s2Valid_d  = s2Valid_q;
        s2Result_d = s2Result_q;
        s2Flags_d  = s2Flags_q;
        if (s2Advance) begin
            s2Valid_d = s1Valid_q;
        end
        if (s2Advance && s1Valid_q) begin
            case (s1Class_q)
                CLS_ZERO: begin
                    s2Result_d = {s1Sign_q, 31'd0};
                    s2Flags_d  = 3'b000;
                end
                CLS_INF: begin
                    s2Result_d = {s1Sign_q, 8'hFF, 23'd0};
                    s2Flags_d  = 3'b000;
                end
                CLS_NORM: begin
                    s2Result_d = {s1Sign_q, s1Exp_q, s1Frac_q};
                    s2Flags_d  = 3'b000;
                end
                CLS_OVF: begin
                    s2Result_d = {s1Sign_q, 8'hFF, 23'd0};
                    s2Flags_d  = 3'b010;
                end
                CLS_UNF: begin
                    s2Result_d = {s1Sign_q, 8'h00, s1Frac_q};
                    s2Flags_d  = 3'b001;
                end
                default: begin
                    s2Result_d = 32'h7FC00000;
                    s2Flags_d  = 3'b100;
                end
            endcase
        end
    end

    // Pipeline registers with synchronous active-low reset discarding anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s1Sign_q   <= 1'b0;
            s1Class_q  <= CLS_ZERO;
            s1Exp_q    <= 8'd0;
            s1Frac_q   <= 23'd0;
            s2Valid_q  <= 1'b0;
            s2Result_q <= 32'd0;
            s2Flags_q  <= 3'd0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Sign_q   <= s1Sign_d;
            s1Class_q  <= s1Class_d;
            s1Exp_q    <= s1Exp_d;
            s1Frac_q   <= s1Frac_d;
            s2Valid_q  <= s2Valid_d;
            s2Result_q <= s2Result_d;
            s2Flags_q  <= s2Flags_d;
        end
    end

    assign bus.out_valid  = s2Valid_q;
    assign bus.out_result = s2Result_q;
    assign bus.out_flags  = s2Flags_q;

endmodule

// File: doc/fp_result_packer.md
FP_RESULT_PACKER -- requirements
Module: fp_result_packer

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  upstream result present.
REQ-005 in_ready  output  1  packer can accept; transfer on in_valid && in_ready.
REQ-006 in_sign  input  1  result sign.
REQ-007 in_exp  input  10  two's-complement biased exponent (bias 127), pre-range-check.
REQ-008 in_mant  input  24  significand, hidden bit at [23], normalized when nonzero.
REQ-009 in_special  input  3  class code: 000 normal, 001 zero, 010 inf, 011 NaN; others treated as NaN.
REQ-010 out_valid  output  1  packed word present.
REQ-011 out_ready  input  1  downstream accepts; transfer on out_valid && out_ready.
REQ-012 out_result  output  32  IEEE-754 single-precision word.
REQ-013 out_flags  output  3  {invalid, overflow, underflow} for out_result.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 classifies/range-checks, S2 assembles; latency 2 cycles from accept to out_valid with out_ready held high.
REQ-015 SHALL sustain 1 result/cycle when out_ready is high.
REQ-016 in_ready SHALL be high when S1 empty, or when S1 advances this cycle (S2 empty or out_ready high).
REQ-017 S2 SHALL hold out_result/out_flags/out_valid stable while out_valid && !out_ready.
REQ-018 Simultaneous accept at S1 and drain at S2 SHALL lose and duplicate nothing.
REQ-019 zero class -> {in_sign, 31'b0}, flags 000.
REQ-020 inf class -> {in_sign, 8'hFF, 23'b0}, flags 000.
REQ-021 NaN class or codes 100-111 -> 32'h7FC00000, invalid=1.
REQ-022 normal, in_mant==0 -> signed zero, flags 000.
REQ-023 normal, in_exp >= 255 -> signed infinity, overflow=1.
REQ-024 normal, 1 <= in_exp <= 254 -> {in_sign, in_exp[7:0], in_mant[22:0]}, flags 000.
REQ-025 normal, in_exp <= 0 -> underflow path per REQ-030/031, underflow=1.
REQ-026 in_mant[23]==0 with nonzero mantissa on normal class SHALL pack mant[22:0] unchanged (no renormalization); bench SHALL NOT drive it.

Reset
REQ-027 rst_n low at rising edge SHALL clear S1/S2 valid, set out_valid=0, out_result=0, out_flags=0.
REQ-028 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-029 Reset mid-operation SHALL discard in-flight results; no output for them after release.

Configuration
REQ-030 Macro PACKER_FTZ_EN defined: underflow results flush to {in_sign, 31'b0}.
REQ-031 Macro undefined: shift = 1 - in_exp; shift <= 23 -> {in_sign, 8'h00, (in_mant >> shift)[22:0]}, truncating; shift > 23 -> signed zero. underflow=1 in both cases.

Verification
REQ-032 normal, sign 0, exp 129, mant 24'hDCCCCD (6.9) -> out_result 32'h40DCCCCD, flags 000, out_valid 2 cycles after accept.
REQ-033 normal exp 300; then NaN class -> 32'h7F800000 with overflow=1; then 32'h7FC00000 with invalid=1.
REQ-034 zero class sign 1; then normal exp 0 mant 24'h800000 -> 32'h80000000; then 32'h00400000 without PACKER_FTZ_EN, 32'h00000000 with it, underflow=1.
REQ-035 back-to-back 4 inputs, out_ready low 3 cycles mid-stream -> outputs in order, none lost or duplicated, in_ready drops within 1 cycle of stage saturation.
REQ-036 rst_n low for 1 cycle with 2 results in flight -> out_valid 0 next cycle, no stale outputs after release, in_ready 1.
